// File: rtl/mcyc_pkg.sv
// Shared definitions for the multicycle MIPS control block.
// Holds the FSM state encoding, opcode/funct constants and the codes driven
// on alu_op, pc_sel, alu_src_b and fault_code. Imported by mcyc_alu_dec and
// mcyc_ctrl.
package mcyc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_code_e;

  // Opcodes that have an EXEC sequence (HALT is handled separately).
  function automatic logic known_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mcyc_alu_dec.sv
// R-type function decoder: maps funct to an ALU operation and flags any
// funct outside the supported set as illegal.
// Ports:
//   funct   in  6  IR[5:0]
//   alu_op  out 4  ALU operation (ADD for unsupported funct)
//   illegal out 1  funct not supported
module mcyc_alu_dec
  import mcyc_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       illegal
);

  // NOTE: every output gets a default before the case; without it an
  // unmatched funct would hold the previous value and infer a latch.
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcyc_ctrl.sv
// Multicycle MIPS control FSM. Drives the datapath register load enables,
// mux selects, ALU operation and a req/ack memory interface with a
// wait-state timeout.
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   opcode, funct         IR[31:26], IR[5:0]
//   zero                  ALU zero flag
//   mem_ack               memory completes the current request
//   ld_pc..ld_mdr         datapath register load enables
//   pc_sel, alu_src_a, alu_src_b, alu_op   datapath mux / ALU controls
//   mem_req, mem_we, iord memory request, write strobe, address select
//   reg_we, reg_dst, mem_to_reg            register-file write controls
//   halted, fault         sticky terminal-state flags
//   fault_code            00 none, 01 illegal op, 10 memory timeout
//   state                 current FSM state (debug)
// Configuration: define MCYC_CTRL_ILLEGAL_TRAP_EN to send unknown opcodes and
// unknown R-type funct codes to FAULT; otherwise they are NOP / ADD.
module mcyc_ctrl
  import mcyc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int          ST_W        = 3
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            ld_pc,
  output logic            ld_ir,
  output logic            ld_a,
  output logic            ld_b,
  output logic            ld_alu,
  output logic            ld_mdr,
  output logic [1:0]      pc_sel,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_op,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            reg_we,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [ST_W-1:0] state
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_code_q, fault_code_d;

  alu_op_e dec_op;
  logic    dec_illegal;
  logic    mem_expired;
  logic    op_ok;

  mcyc_alu_dec u_alu_dec (
    .funct   (funct),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  // Ack in the same cycle as the limit is reached still completes the access.
  assign mem_expired = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT)) && !mem_ack;
  assign op_ok       = known_opcode(opcode) || (opcode == OP_HALT);

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    ld_pc        = 1'b0;
    ld_ir        = 1'b0;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    ld_alu       = 1'b0;
    ld_mdr       = 1'b0;
    pc_sel       = PC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_AND;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ack) begin
          ld_ir   = 1'b1;
          ld_pc   = 1'b1;
          pc_sel  = PC_ALU;
          state_d = S_DECODE;
        end else if (mem_expired) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end

      S_DECODE: begin
        // ALUOut captures the branch target while A/B read the register file.
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_ADD;
`ifdef MCYC_CTRL_ILLEGAL_TRAP_EN
        ld_a   = op_ok;
        ld_b   = op_ok;
        ld_alu = op_ok;
`else
        ld_a   = 1'b1;
        ld_b   = 1'b1;
        ld_alu = 1'b1;
`endif
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (op_ok) begin
          state_d = S_EXEC;
        end else begin
`ifdef MCYC_CTRL_ILLEGAL_TRAP_EN
          state_d      = S_FAULT;
          fault_code_d = FC_ILLEGAL;
`else
          state_d = S_FETCH;
`endif
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            // Unsupported funct falls back to ADD when not trapping.
            alu_op    = dec_illegal ? ALU_ADD : dec_op;
`ifdef MCYC_CTRL_ILLEGAL_TRAP_EN
            if (dec_illegal) begin
              state_d      = S_FAULT;
              fault_code_d = FC_ILLEGAL;
            end else begin
              ld_alu  = 1'b1;
              state_d = S_WB;
            end
`else
            ld_alu  = 1'b1;
            state_d = S_WB;
`endif
          end
          OP_LW, OP_SW, OP_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            ld_alu    = 1'b1;
            state_d   = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_BEQ: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = ALU_SUB;
            if (zero) begin
              ld_pc  = 1'b1;
              pc_sel = PC_ALUOUT;
            end
          end
          OP_J: begin
            ld_pc  = 1'b1;
            pc_sel = PC_JUMP;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ack) begin
          if (opcode == OP_LW) begin
            ld_mdr  = 1'b1;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (mem_expired) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LW);
        state_d = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
    endcase
  end

  // Wait-state counter restarts whenever the FSM changes state, so it is
  // zero on entry to FETCH and MEM; it saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_req && !mem_ack && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign halted     = (state_q == S_HALT);
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fault_code_q;
  assign state      = ST_W'(state_q);

endmodule
